// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the two-port data-memory arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   - DMEM_DEPTH  : number of valid memory words
//   - DMEM_DW     : memory data width
//   - PORT_CPU / PORT_DBG : port indices (load/store unit, debug/loader)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int   DMEM_DEPTH = 100;
    localparam int   DMEM_DW    = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational grant selection between the two request ports.
// Default: round-robin, the port that did not win last time wins a tie.
// With DMEM_ARB_FIXED_PRIO_EN defined, port 0 always wins a tie and
// last_grant is ignored.
// Ports:
//   req0, req1  in  : request lines of port 0 / port 1
//   last_grant  in  : port that received the previous grant
//   valid       out : at least one port is requesting
//   winner      out : index of the port to grant (meaningful when valid=1)
// -----------------------------------------------------------------------------
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Select the winning port for the current IDLE cycle.
    always_comb begin
        valid = req0 | req1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (req0) begin
            winner = PORT_CPU;
        end else begin
            winner = PORT_DBG;
        end
`else
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req0) begin
            winner = PORT_CPU;
        end else begin
            winner = PORT_DBG;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Serialises two request ports onto one single-port data memory through an
// IDLE -> ACCESS -> RESP FSM. Out-of-range addresses never write memory and
// complete with err=1 and rdata=0.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 0 always wins a tie).
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN   : port N request, write enable, word address, data
//   ackN/rdataN/errN        : port N one-cycle completion, read data, range error
//   mem_a/mem_wd/mem_we     : registered memory address / write data / write enable
//   mem_rd                  : memory read data (combinational from mem_a)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DW    = DMEM_DW,
    parameter int AW    = 32,
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    arb_state_t    state_r;
    logic          last_grant_r;
    logic          cmd_port_r;
    logic          cmd_we_r;
    logic          cmd_oob_r;

    logic          pick_valid_s;
    logic          pick_winner_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;
    logic          win_in_range_s;
    logic [DW-1:0] resp_data_s;

    dmem_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // Route the winning port's command fields and range-check its address.
    always_comb begin
        if (pick_winner_s == PORT_CPU) begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end else begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end
        win_in_range_s = (win_addr_s < AW'(DEPTH));
    end

    // Response data: only an in-range read returns memory contents.
    always_comb begin
        if (!cmd_oob_r && !cmd_we_r) begin
            resp_data_s = mem_rd;
        end else begin
            resp_data_s = {DW{1'b0}};
        end
    end

    // Arbiter FSM with registered memory pins and per-port response registers.
    // mem_we is part of the async reset, so a reset during ACCESS kills the
    // pending write before the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= PORT_DBG;
            cmd_port_r   <= PORT_CPU;
            cmd_we_r     <= 1'b0;
            cmd_oob_r    <= 1'b0;
            mem_a        <= {AW{1'b0}};
            mem_wd       <= {DW{1'b0}};
            mem_we       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= {DW{1'b0}};
            rdata1       <= {DW{1'b0}};
            err0         <= 1'b0;
            err1         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    mem_we <= 1'b0;
                    if (pick_valid_s) begin
                        state_r      <= ACCESS;
                        last_grant_r <= pick_winner_s;
                        cmd_port_r   <= pick_winner_s;
                        cmd_we_r     <= win_we_s;
                        cmd_oob_r    <= ~win_in_range_s;
                        mem_a        <= win_addr_s;
                        mem_wd       <= win_wdata_s;
                        mem_we       <= win_we_s & win_in_range_s;
                    end
                end
                ACCESS: begin
                    state_r <= RESP;
                    mem_we  <= 1'b0;
                    if (cmd_port_r == PORT_CPU) begin
                        ack0   <= 1'b1;
                        rdata0 <= resp_data_s;
                        err0   <= cmd_oob_r;
                    end else begin
                        ack1   <= 1'b1;
                        rdata1 <= resp_data_s;
                        err1   <= cmd_oob_r;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
